ad_nios_lcell_counter: RTL
==========================

AD_NIOS_LCELL_COUNTER -- requirements
Module: ad_nios_lcell_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (range 2..32).
REQ-002 SHALL have parameter MODULUS, default 0, count modulus; 0 means 2**WIDTH; otherwise 2..2**WIDTH.
REQ-003 SHALL have parameter POWER_UP, default 0, value loaded into regout by reset.
REQ-004 SHALL have parameter COUNT_MODE, default MODE_UP, one of MODE_UP, MODE_DOWN, MODE_UPDOWN.
REQ-005 SHALL have parameter OUTPUT_MODE, default OUT_COMB_AND_REG, one of OUT_REG_ONLY, OUT_COMB_AND_REG.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ena  input  1  clock enable; gates sclr, sload and count.
REQ-009 sclr  input  1  synchronous clear to 0.
REQ-010 sload  input  1  synchronous load of sdata.
REQ-011 sdata  input  WIDTH  load value.
REQ-012 cin  input  1  count-enable carry-in from previous stage; tie 1 when unchained.
REQ-013 updown  input  1  1 = up, 0 = down; used only in MODE_UPDOWN.
REQ-014 regout  output  WIDTH  registered count.
REQ-015 combout  output  WIDTH  next-state value before register.
REQ-016 cout  output  1  combinational carry-out to the next stage.
REQ-017 tc  output  1  registered one-cycle terminal-count (wrap) pulse.

Function
REQ-018 Per-edge priority SHALL be: reset, then (if ena) sclr, then sload, then count when cin=1, else hold.
REQ-019 Effective modulus M SHALL be 2**WIDTH when MODULUS=0, else MODULUS; all arithmetic is modulo M in WIDTH bits.
REQ-020 Up count: regout >= M-1 -> 0 (wrap); else regout+1.
REQ-021 Down count: regout = 0 -> M-1 (wrap); regout >= M -> regout-1; else regout-1.
REQ-022 Direction: MODE_UP always up; MODE_DOWN always down; MODE_UPDOWN follows updown sampled the same cycle.
REQ-023 sload SHALL load sdata unmodified, including values >= M; the next up count from such a value wraps to 0.
REQ-024 combout SHALL equal the value regout takes on the next edge given current inputs, excluding reset; latency 0.
REQ-025 OUTPUT_MODE=OUT_REG_ONLY SHALL drive combout to 0.
REQ-026 cout SHALL be ena & cin & ~sclr & ~sload & (count would wrap this cycle), combinational, for ripple cascading.
REQ-027 tc SHALL be 1 for exactly the cycle after an edge on which a count wrap occurred; 0 after sclr, sload, hold or reset.
REQ-028 Simultaneous sclr and sload SHALL clear; sload with cin=0 SHALL still load.
REQ-029 ena=0 SHALL hold regout and force tc to 0 on that edge.

Reset
REQ-030 Reset SHALL set regout=POWER_UP mod M and tc=0 on the next edge, overriding all other inputs.
REQ-031 Reset asserted mid-count SHALL discard any pending wrap; tc SHALL be 0 in the cycle after reset.
REQ-032 combout and cout SHALL reflect post-reset regout from the cycle after reset.

Structure
REQ-033 Package ad_nios_lcell_pkg SHALL hold the COUNT_MODE and OUTPUT_MODE constants/typedefs.
REQ-034 Sub-module ad_nios_lcell_next (combinational next-value and wrap flag) SHALL be instantiated once.
REQ-035 Chaining: cout of stage k feeds cin of stage k+1; no cross-stage state.

Verification
REQ-036 WIDTH=4, MODULUS=10, MODE_UP, cin=1, ena=1, 12 edges from 0 -> regout 1..9,0,1,2; tc high only in the cycle regout=0; cout high while regout=9.
REQ-037 WIDTH=4, MODULUS=0, MODE_UPDOWN, load 0 then updown=0 -> regout 15, tc=1 next cycle; updown=1 -> 0, tc=1.
REQ-038 sclr=1, sload=1, sdata=5 same edge -> regout 0; then sload alone, sdata=12, M=10 -> regout 12; next up edge -> 0, tc=1.
REQ-039 Two WIDTH=4 default stages chained, 300 edges -> combined 8-bit value = 300 mod 256 = 44, upper stage only advancing on lower wrap.
REQ-040 POWER_UP=7, reset asserted during count at regout=9 (M=10) -> regout 7, tc 0; ena=0 three edges -> regout stays 7.

Source files
------------

// File: rtl/ad_nios_lcell_pkg.sv
// Shared mode enumerations and parameter-derived constants for the lcell counter slice.
package ad_nios_lcell_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_UPDOWN = 2'd2
    } count_mode_e;

    typedef enum logic {
        OUT_REG_ONLY     = 1'b0,
        OUT_COMB_AND_REG = 1'b1
    } output_mode_e;

    localparam int unsigned WIDTH_MAX = 32;

    function automatic logic [31:0] width_mask(input int unsigned width);
        return 32'hFFFF_FFFF >> (WIDTH_MAX - width);
    endfunction

    // Largest reachable count (M-1); MODULUS of 0 selects the full 2**width range.
    function automatic logic [31:0] max_count(input int unsigned width, input int unsigned modulus);
        return (modulus == 0) ? width_mask(width) : 32'(modulus - 1);
    endfunction

    function automatic logic [31:0] power_up_value(input int unsigned width, input int unsigned modulus,
                                                   input int unsigned power_up);
        return (modulus == 0) ? (32'(power_up) & width_mask(width)) : 32'(power_up % modulus);
    endfunction

endpackage

// File: rtl/ad_nios_lcell_counter_if.sv
// Control/data bundle between a counter stage and whatever drives it.
interface ad_nios_lcell_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ena;
    logic             sclr;
    logic             sload;
    logic [WIDTH-1:0] sdata;
    logic             cin;
    logic             updown;
    logic [WIDTH-1:0] regout;
    logic [WIDTH-1:0] combout;
    logic             cout;
    logic             tc;

    modport master (
        output ena, sclr, sload, sdata, cin, updown,
        input  regout, combout, cout, tc
    );

    modport slave (
        input  ena, sclr, sload, sdata, cin, updown,
        output regout, combout, cout, tc
    );
endinterface

// File: rtl/ad_nios_lcell_next.sv
// Combinational next-count selection (clear/load/count/hold) and qualified wrap flag.
module ad_nios_lcell_next
    import ad_nios_lcell_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MODULUS    = 0,
    parameter count_mode_e COUNT_MODE = MODE_UP
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic             i_ena,
    input  logic             i_sclr,
    input  logic             i_sload,
    input  logic [WIDTH-1:0] i_sdata,
    input  logic             i_cin,
    input  logic             i_updown,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_count(WIDTH, MODULUS));

    logic             w_up;
    logic [WIDTH-1:0] w_step;
    logic             w_step_wrap;

    assign w_up = (COUNT_MODE == MODE_UP)   ? 1'b1 :
                  (COUNT_MODE == MODE_DOWN) ? 1'b0 : i_updown;

    // Values loaded at or above M-1 wrap to zero on the next up count.
    always_comb begin
        w_step      = i_cur;
        w_step_wrap = 1'b0;
        if (w_up) begin
            if (i_cur >= MAX_VAL) begin
                w_step      = '0;
                w_step_wrap = 1'b1;
            end else begin
                w_step = i_cur + WIDTH'(1);
            end
        end else begin
            if (i_cur == '0) begin
                w_step      = MAX_VAL;
                w_step_wrap = 1'b1;
            end else begin
                w_step = i_cur - WIDTH'(1);
            end
        end
    end

    always_comb begin
        o_next = i_cur;
        o_wrap = 1'b0;
        if (i_ena) begin
            if (i_sclr) begin
                o_next = '0;
            end else if (i_sload) begin
                o_next = i_sdata;
            end else if (i_cin) begin
                o_next = w_step;
                o_wrap = w_step_wrap;
            end
        end
    end

endmodule

// File: rtl/ad_nios_lcell_counter.sv
// Cascadable modulo counter stage: registered count and wrap pulse, combinational look-ahead and carry.
module ad_nios_lcell_counter
    import ad_nios_lcell_pkg::*;
#(
    parameter int unsigned  WIDTH       = 8,
    parameter int unsigned  MODULUS     = 0,
    parameter int unsigned  POWER_UP    = 0,
    parameter count_mode_e  COUNT_MODE  = MODE_UP,
    parameter output_mode_e OUTPUT_MODE = OUT_COMB_AND_REG
) (
    input  logic                          clk,
    input  logic                          reset,
    ad_nios_lcell_counter_if.slave        bus
);

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(power_up_value(WIDTH, MODULUS, POWER_UP));

    logic [WIDTH-1:0] r_regout;
    logic             r_tc;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    ad_nios_lcell_next #(
        .WIDTH      (WIDTH),
        .MODULUS    (MODULUS),
        .COUNT_MODE (COUNT_MODE)
    ) u_next (
        .i_cur    (r_regout),
        .i_ena    (bus.ena),
        .i_sclr   (bus.sclr),
        .i_sload  (bus.sload),
        .i_sdata  (bus.sdata),
        .i_cin    (bus.cin),
        .i_updown (bus.updown),
        .o_next   (w_next),
        .o_wrap   (w_wrap)
    );

    // Reset overrides everything, including a wrap pending on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regout <= RESET_VAL;
            r_tc     <= 1'b0;
        end else begin
            r_regout <= w_next;
            r_tc     <= w_wrap;
        end
    end

    assign bus.regout  = r_regout;
    assign bus.tc      = r_tc;
    assign bus.cout    = w_wrap;
    assign bus.combout = (OUTPUT_MODE == OUT_REG_ONLY) ? '0 : w_next;

endmodule
